// File: rtl/ecc_secded_dec_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with valid qualification.
// Optional saturating error-event counters are built when ECC_SECDED_DEC_CNT_EN is defined.
module ecc_secded_dec_pipe #(
    parameter int DW   = 8,
    parameter int PW   = 4,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivld,
    input  logic [DW+PW:0]     idat,
    input  logic               dis,
    output logic               ovld,
    output logic [DW-1:0]      odat,
    output logic               osec,
    output logic               oded,
    output logic [PW-1:0]      osyn,
    input  logic               cnt_clr,
    output logic [CNTW-1:0]    sec_cnt,
    output logic [CNTW-1:0]    ded_cnt
);

    localparam int CW = DW + PW + 1;
    localparam int NP = DW + PW;

    function automatic int min_pw(input int dw);
        int r;
        r = 0;
        for (int p = 8; p >= 1; p--) begin
            if ((1 << p) >= dw + p + 1) r = p;
        end
        return r;
    endfunction

    // Hamming position of data bit j: the j-th position that is not a power of two.
    function automatic int data_pos(input int j);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int i = 1; i < 128; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == j) r = i;
                n++;
            end
        end
        return r;
    endfunction

    if (PW != min_pw(DW) || DW < 4 || DW > 64 || CNTW < 2 || CNTW > 32) begin : g_bad_param
        $error("ecc_secded_dec_pipe: illegal DW/PW/CNTW combination");
    end

    logic [PW-1:0] syn_c;
    logic          par_c;
    logic [DW-1:0] dat_c;

    always_comb begin
        syn_c = '0;
        for (int i = 1; i <= NP; i++) begin
            for (int k = 0; k < PW; k++) begin
                if (((i >> k) & 1) != 0) syn_c[k] = syn_c[k] ^ idat[i-1];
            end
        end
        par_c = ^idat[CW-1:0];
        if (dis) begin
            syn_c = '0;
            par_c = 1'b0;
        end
        for (int j = 0; j < DW; j++) begin
            dat_c[j] = idat[data_pos(j)-1];
        end
    end

    // stage 1: raw data, syndrome, overall parity
    logic          vld_p1;
    logic [DW-1:0] dat_p1;
    logic [PW-1:0] syn_p1;
    logic          par_p1;
    logic          dis_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            dat_p1 <= '0;
            syn_p1 <= '0;
            par_p1 <= 1'b0;
            dis_p1 <= 1'b0;
        end else begin
            vld_p1 <= ivld;
            dat_p1 <= dat_c;
            syn_p1 <= syn_c;
            par_p1 <= par_c;
            dis_p1 <= dis;
        end
    end

    logic          in_rng;
    logic          sec_c;
    logic          ded_c;
    logic [DW-1:0] odat_c;

    // A syndrome beyond the last codeword position can only come from a multi-bit error.
    assign in_rng = ({1'b0, syn_p1} <= (PW+1)'(NP));
    assign sec_c  = ~dis_p1 & par_p1 & in_rng;
    assign ded_c  = ~dis_p1 & ((par_p1 & ~in_rng) | (~par_p1 & (syn_p1 != '0)));

    always_comb begin
        for (int j = 0; j < DW; j++) begin
            odat_c[j] = dat_p1[j] ^ (sec_c & (syn_p1 == PW'(data_pos(j))));
        end
    end

    // stage 2: corrected data, flags, syndrome
    logic          vld_p2;
    logic [DW-1:0] dat_p2;
    logic [PW-1:0] syn_p2;
    logic          sec_p2;
    logic          ded_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            dat_p2 <= '0;
            syn_p2 <= '0;
            sec_p2 <= 1'b0;
            ded_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            sec_p2 <= vld_p1 & sec_c;
            ded_p2 <= vld_p1 & ded_c;
            if (vld_p1) begin
                dat_p2 <= odat_c;
                syn_p2 <= syn_p1;
            end
        end
    end

    assign ovld = vld_p2;
    assign odat = dat_p2;
    assign osec = sec_p2;
    assign oded = ded_p2;
    assign osyn = syn_p2;

`ifdef ECC_SECDED_DEC_CNT_EN
    function automatic logic [CNTW-1:0] cnt_next(input logic [CNTW-1:0] cur,
                                                 input logic ev, input logic clr);
        if (clr) return ev ? CNTW'(1) : '0;
        if (ev && cur != '1) return cur + CNTW'(1);
        return cur;
    endfunction

    logic [CNTW-1:0] sec_cnt_p2;
    logic [CNTW-1:0] ded_cnt_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt_p2 <= '0;
            ded_cnt_p2 <= '0;
        end else begin
            sec_cnt_p2 <= cnt_next(sec_cnt_p2, vld_p1 & sec_c, cnt_clr);
            ded_cnt_p2 <= cnt_next(ded_cnt_p2, vld_p1 & ded_c, cnt_clr);
        end
    end

    assign sec_cnt = sec_cnt_p2;
    assign ded_cnt = ded_cnt_p2;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sec_cnt = '0;
    assign ded_cnt = '0;
`endif

endmodule
